// File: rtl/vga_cell_painter_if.sv
// ---------------------------------------------------------------------------
// vga_cell_painter_if
// Groups the request handshake and the pixel-write bus of the cell painter.
//   sync_ok   : background load finished; gates request acceptance
//   req       : draw request, with x0 / y0 (cell top-left) and mode
//   abort     : cancel the draw in progress
//   ready     : painter idle and able to accept
//   pix_x/pix_y/pix_color/pix_write : one pixel write per clock to the adapter
//   done      : one-cycle pulse after the last pixel of a complete cell
// master = requester / frame-memory side, slave = painter.
// ---------------------------------------------------------------------------
interface vga_cell_painter_if #(
  parameter int COLOR_DEPTH = 9
);
  logic                   sync_ok;
  logic                   req;
  logic [9:0]             x0;
  logic [8:0]             y0;
  logic [1:0]             mode;
  logic                   abort;
  logic                   ready;
  logic [9:0]             pix_x;
  logic [8:0]             pix_y;
  logic [COLOR_DEPTH-1:0] pix_color;
  logic                   pix_write;
  logic                   done;

  modport master (
    output sync_ok, req, x0, y0, mode, abort,
    input  ready, pix_x, pix_y, pix_color, pix_write, done
  );

  modport slave (
    input  sync_ok, req, x0, y0, mode, abort,
    output ready, pix_x, pix_y, pix_color, pix_write, done
  );
endinterface

// File: rtl/vga_cell_painter.sv
// ---------------------------------------------------------------------------
// vga_cell_painter
// Paints one CELL_W x CELL_H step-sequencer cell into the VGA adapter's frame
// memory, one pixel write per clock in raster order, with optional 1-pixel
// border, screen clipping, abort and a completion pulse.
// Ports:
//   CLOCK_50 : system clock
//   nReset   : asynchronous active-low reset
//   bus      : vga_cell_painter_if.slave (request handshake + pixel bus)
// ---------------------------------------------------------------------------
module vga_cell_painter #(
  parameter int                     CELL_W       = 30,
  parameter int                     CELL_H       = 30,
  parameter int                     COLOR_DEPTH  = 9,
  parameter int                     SCREEN_W     = 640,
  parameter int                     SCREEN_H     = 480,
  parameter int                     BORDER       = 1,
  parameter logic [COLOR_DEPTH-1:0] COLOR_OFF    = 9'h007,
  parameter logic [COLOR_DEPTH-1:0] COLOR_ON     = 9'h1FF,
  parameter logic [COLOR_DEPTH-1:0] COLOR_PLAY   = 9'h1C0,
  parameter logic [COLOR_DEPTH-1:0] COLOR_BG     = 9'h000,
  parameter logic [COLOR_DEPTH-1:0] COLOR_BORDER = 9'h049
) (
  input logic              CLOCK_50,
  input logic              nReset,
  vga_cell_painter_if.slave bus
);

  localparam int CXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int CYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam logic [CXW-1:0] CX_LAST = CXW'(CELL_W - 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(CELL_H - 1);
  localparam logic [10:0]    SCR_W   = 11'(SCREEN_W);
  localparam logic [9:0]     SCR_H   = 10'(SCREEN_H);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]             state_reg;
  logic                   armed_reg;   // low until the first clock after reset
  logic [9:0]             x0_reg;
  logic [8:0]             y0_reg;
  logic [1:0]             mode_reg;
  logic [CXW-1:0]         cx_reg;
  logic [CYW-1:0]         cy_reg;
  logic [9:0]             pix_x_reg;
  logic [8:0]             pix_y_reg;
  logic [COLOR_DEPTH-1:0] pix_color_reg;
  logic                   pix_write_reg;
  logic                   done_reg;

  logic                   accept;
  logic                   last_px;
  logic [9:0]             base_x;
  logic [8:0]             base_y;
  logic [1:0]             base_mode;
  logic [CXW-1:0]         cx_next;
  logic [CYW-1:0]         cy_next;
  logic [10:0]            sum_x;
  logic [9:0]             sum_y;
  logic                   in_view;
  logic                   perim;
  logic [COLOR_DEPTH-1:0] fill_color;
  logic [COLOR_DEPTH-1:0] color_next;

  // The outputs are registered, so everything below describes the pixel that
  // will be presented in the *next* cycle. In IDLE that is pixel (0,0) of the
  // incoming request, taken straight from the bus; in DRAW it is the raster
  // successor of the pixel currently on the outputs.
  always_comb begin
    accept  = (state_reg == ST_IDLE) && armed_reg && bus.sync_ok && bus.req;
    last_px = (cx_reg == CX_LAST) && (cy_reg == CY_LAST);

    if (state_reg == ST_IDLE) begin
      base_x    = bus.x0;
      base_y    = bus.y0;
      base_mode = bus.mode;
      cx_next   = '0;
      cy_next   = '0;
    end else begin
      base_x    = x0_reg;
      base_y    = y0_reg;
      base_mode = mode_reg;
      if (cx_reg == CX_LAST) begin
        cx_next = '0;
        cy_next = cy_reg + 1'b1;
      end else begin
        cx_next = cx_reg + 1'b1;
        cy_next = cy_reg;
      end
    end

    // One extra bit on each axis so a cell hanging off the screen edge is
    // clipped instead of wrapping back to column/row 0.
    sum_x   = {1'b0, base_x} + 11'(cx_next);
    sum_y   = {1'b0, base_y} + 10'(cy_next);
    in_view = (sum_x < SCR_W) && (sum_y < SCR_H);

    perim = (cx_next == '0) || (cx_next == CX_LAST) ||
            (cy_next == '0) || (cy_next == CY_LAST);

    case (base_mode)
      2'd0:    fill_color = COLOR_OFF;
      2'd1:    fill_color = COLOR_ON;
      2'd2:    fill_color = COLOR_PLAY;
      default: fill_color = COLOR_BG;
    endcase

    // Erase (mode 3) must wipe the border too, so it never gets one.
    if ((BORDER != 0) && (base_mode != 2'd3) && perim)
      color_next = COLOR_BORDER;
    else
      color_next = fill_color;
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      state_reg     <= ST_IDLE;
      armed_reg     <= 1'b0;
      x0_reg        <= '0;
      y0_reg        <= '0;
      mode_reg      <= '0;
      cx_reg        <= '0;
      cy_reg        <= '0;
      pix_x_reg     <= '0;
      pix_y_reg     <= '0;
      pix_color_reg <= '0;
      pix_write_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      armed_reg     <= 1'b1;
      pix_write_reg <= 1'b0;
      done_reg      <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            x0_reg        <= bus.x0;
            y0_reg        <= bus.y0;
            mode_reg      <= bus.mode;
            cx_reg        <= '0;
            cy_reg        <= '0;
            state_reg     <= ST_DRAW;
            pix_write_reg <= in_view;
            // Coordinates/colour only move on a real write; clipped pixels
            // leave the last written values on the bus.
            if (in_view) begin
              pix_x_reg     <= sum_x[9:0];
              pix_y_reg     <= sum_y[8:0];
              pix_color_reg <= color_next;
            end
          end
        end

        ST_DRAW: begin
          if (bus.abort) begin
            // The pixel on the bus this cycle was still a valid write.
            state_reg <= ST_IDLE;
          end else if (last_px) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else begin
            cx_reg        <= cx_next;
            cy_reg        <= cy_next;
            pix_write_reg <= in_view;
            if (in_view) begin
              pix_x_reg     <= sum_x[9:0];
              pix_y_reg     <= sum_y[8:0];
              pix_color_reg <= color_next;
            end
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready     = (state_reg == ST_IDLE) && armed_reg && bus.sync_ok;
  assign bus.pix_x     = pix_x_reg;
  assign bus.pix_y     = pix_y_reg;
  assign bus.pix_color = pix_color_reg;
  assign bus.pix_write = pix_write_reg;
  assign bus.done      = done_reg;

endmodule
